// File: rtl/uart_fifo_sync.sv
// Parametrised single-clock UART FIFO: threshold flag, sticky errors, flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module uart_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int ABITS = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [ABITS:0]   level,
  output logic [WIDTH-1:0] data_out,
  output logic [ABITS:0]   count,
  output logic             full,
  output logic             empty,
  output logic             half,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ABITS:0]   FULL_C = (ABITS+1)'(DEPTH);
  localparam logic [ABITS-1:0] LAST_C = ABITS'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_ok, wr_ok;
  logic             ovf_ev, udf_ev;

  assign full      = (count_q == FULL_C);
  assign empty     = (count_q == '0);
  assign half      = (count_q >= level);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // Flush swallows any same-cycle strobe, including its error events.
  always_comb begin
    rd_ok  = 1'b0;
    wr_ok  = 1'b0;
    ovf_ev = 1'b0;
    udf_ev = 1'b0;
    if (!flush) begin
      rd_ok  = !read_n && !empty;
      wr_ok  = !write_n && (!full || rd_ok);
      ovf_ev = !write_n && !wr_ok;
      udf_ev = !read_n && empty;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok)
        wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      if (rd_ok)
        rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      unique case (1'b1)
        wr_ok && !rd_ok: count_d = count_q + 1'b1;
        rd_ok && !wr_ok: count_d = count_q - 1'b1;
        default:         count_d = count_q;
      endcase
    end
    ovf_d = ovf_ev || (ovf_q && !clr_err);
    udf_d = udf_ev || (udf_q && !clr_err);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok)
      mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_ok)
      dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dout_q <= '0;
    else
      dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

endmodule

// File: doc/uart_fifo_sync.md
# uart_fifo_sync

Parametrised single-clock FIFO, the successor to the fixed 128x8 UART buffer. It provides generic width and depth, true full at DEPTH entries and a programmable threshold flag. It also adds guarded overflow/underflow with sticky error flags, a synchronous flush, an occupancy count, and an optional first-word-fall-through read mode. It sits between the APB register interface and the UART TX/RX shift logic, and is instantiated once per direction.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 128, number of storage entries (≥2; any value, not restricted to powers of 2)
- ABITS, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  reset, asynchronous and active-high
- flush  in  1  synchronous clear of pointers and count, active-high
- clr_err  in  1  synchronous clear of overflow/underflow, active-high
- data_in  in  WIDTH  write data
- write_n  in  1  write strobe, active-low
- read_n  in  1  read strobe, active-low
- level  in  ABITS+1  threshold for half
- data_out  out  WIDTH  read data
- count  out  ABITS+1  occupied entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- half  out  1  count ≥ level
- overflow  out  1  sticky: write attempted while full and not reading
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: WIDTH x DEPTH register array, not reset; write at wr_ptr, read at rd_ptr.
- Pointers advance by 1 and wrap from DEPTH-1 to 0.
- Accepted write (wr_ok): write_n=0 and (full=0 or rd_ok).
- Accepted read (rd_ok): read_n=0 and empty=0.
- Count update:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither occur
- Full with simultaneous read+write: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous read+write: write accepted, read rejected, underflow set, count becomes 1.
- Rejected write: memory and wr_ptr untouched, overflow ← 1.
- Rejected read: rd_ptr and data_out untouched, underflow ← 1.
- Flags:
  - full, empty and half are decoded from registered count, so there is no extra register stage.
  - half uses unsigned compare; level=0 forces half=1; level>DEPTH forces half=0.
- flush: rd_ptr, wr_ptr and count ← 0 and any same-cycle read/write is ignored. Error flags and data_out are kept.
- clr_err: clears overflow/underflow. A same-cycle error event wins and the flag stays 1.
- Reset values: count 0, empty 1, full 0, half = (level==0), overflow 0, underflow 0, data_out 0, pointers 0.
- Reset during traffic discards contents immediately; the first accepted write after release lands in entry 0.

## Timing
- Standard mode: on a rd_ok edge, data_out ← mem[rd_ptr]. The word is visible one clock after the strobe is sampled. data_out holds between reads.
- Write-to-flag: empty falls and count updates in the cycle after the write edge.
- Write-to-read latency: a word written at edge N can be read (rd_ok) at edge N+1.
- Flag updates: full/half/count change on the same edge as the accepted operation.
- Strobes are level-sampled; a strobe held low for k cycles performs k operations.

## Configuration
- FIFO_FWFT_EN defined:
  - data_out = mem[rd_ptr] combinationally, so the head word is valid whenever empty=0.
  - rd_ok pops it, and the next word appears after that edge.
  - data_out is don't-care while empty; reset value is not defined.
- FIFO_FWFT_EN undefined: registered read as described under Timing; data_out resets to 0.

## Test plan
- Fill/drain, DEPTH=128, WIDTH=8: 128 writes 0x00..0x7F -> full=1 at count=128, no overflow. 128 reads -> data 0x00..0x7F in order, empty=1.
- Overflow: at full, write 0xAA with read_n=1 -> overflow=1, count stays 128, and the stored sequence is intact on drain. clr_err -> overflow=0.
- Underflow and simultaneous operations: read while empty -> underflow=1, data_out unchanged. Read+write while empty -> count=1. Read+write while full -> count=128 with no errors.
- Wrap and non-power-of-2: DEPTH=5, 13 interleaved write/read pairs of 0x10..0x1C -> each word is returned in order across pointer wraps.
- Threshold, flush and reset: level=3, three writes -> half rises on the 3rd write edge. flush -> count=0, empty=1, and the next data read is the first write after the flush. Asserting reset mid-burst forces all outputs to their reset values on the same clock.
- FWFT build: a write of 0x5C into an empty FIFO -> data_out=0x5C in the next cycle with read_n=1. A pop then exposes the next word.
